// File: rtl/cache_pkg.sv
// Shared types and constants for the burst-refill cache controller.
package cache_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_WRITE = 3'd2,
        ST_FETCH = 3'd3,
        ST_ALLOC = 3'd4,
        ST_THRU  = 3'd5
    } state_t;

    // Commands issued to the set.
    typedef enum logic [2:0] {
        CTRL_NOP   = 3'b000,
        CTRL_FILL  = 3'b001,
        CTRL_ALLOC = 3'b010,
        CTRL_READ  = 3'b100,
        CTRL_WRITE = 3'b101
    } ctrl_t;

    // Words per line for a given byte-offset width.
    function automatic int words_of(input int line_width);
        return 2 ** (line_width - 2);
    endfunction

    localparam int DEF_LINE_WIDTH = 6;
    localparam int WORDS          = words_of(DEF_LINE_WIDTH);

endpackage

// File: rtl/burst_cache_fsm.sv
// Miss-handling state machine and burst beat counter.
module burst_cache_fsm
    import cache_pkg::*;
#(
    parameter int TAG_WIDTH  = 20,
    parameter int LINE_WIDTH = 6,
    parameter int KEY_WIDTH  = 2,
    parameter int WRITE_BACK = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  write_en,
    input  logic                  line_hit,
    input  logic                  line_dirty,
    input  logic [TAG_WIDTH-1:0]  line_tag,
    input  logic [KEY_WIDTH-1:0]  line_key,
    input  logic                  mack,
    output state_t                state,
    output logic [LINE_WIDTH-3:0] beat,
    output logic [KEY_WIDTH-1:0]  victim_key,
    output logic [TAG_WIDTH-1:0]  victim_tag
);

    localparam int BW = LINE_WIDTH - 2;
    localparam logic [BW-1:0] LAST_BEAT = BW'(words_of(LINE_WIDTH) - 1);

    // State, beat and victim latches; a refill always runs to completion once begun.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            beat       <= '0;
            victim_key <= '0;
            victim_tag <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Write-through stores always go to memory, hit or miss.
                    if (en && write_en && (WRITE_BACK == 0))
                        state <= ST_THRU;
                    else if (en && !line_hit)
                        state <= ST_CHECK;
                end
                ST_CHECK: begin
                    victim_key <= line_key;
                    victim_tag <= line_tag;
                    beat       <= '0;
                    state      <= (line_dirty && (WRITE_BACK != 0)) ? ST_WRITE : ST_FETCH;
                end
                ST_WRITE: begin
                    if (mack) begin
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= ST_FETCH;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (mack) begin
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= ST_ALLOC;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                ST_ALLOC: state <= ST_IDLE;
                ST_THRU:  if (mack) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/burst_cache_ctrl.sv
// Cache controller: hit path to the set, burst write-back/refill to memory.
module burst_cache_ctrl
    import cache_pkg::*;
#(
    parameter int TAG_WIDTH  = 20,
    parameter int SET_WIDTH  = 6,
    parameter int LINE_WIDTH = 6,
    parameter int KEY_WIDTH  = 2,
    parameter int WRITE_BACK = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  write_en,
    input  logic [TAG_WIDTH-1:0]  tag,
    input  logic [SET_WIDTH-1:0]  idx,
    input  logic [LINE_WIDTH-1:0] offset,
    input  logic [31:0]           data,
    output logic                  hit,
    output logic                  stall,
    output logic [31:0]           out,
    output logic                  by_tag,
    output logic [TAG_WIDTH-1:0]  target_tag,
    output logic [TAG_WIDTH-1:0]  set_tag,
    output logic [KEY_WIDTH-1:0]  target_key,
    output logic [LINE_WIDTH-1:0] index,
    output logic [2:0]            ctrl,
    output logic [31:0]           write_data,
    output logic [31:0]           set_tick,
    input  logic                  line_hit,
    input  logic                  line_dirty,
    input  logic [31:0]           line_out,
    input  logic [TAG_WIDTH-1:0]  line_tag,
    input  logic [KEY_WIDTH-1:0]  line_key,
    output logic                  mreq,
    output logic                  mwrite_en,
    output logic [31:0]           maddr,
    output logic [31:0]           mdata,
    input  logic                  mack,
    input  logic [31:0]           mout
);

    state_t                  state;
    logic [LINE_WIDTH-3:0]   beat;
    logic [KEY_WIDTH-1:0]    victim_key;
    logic [TAG_WIDTH-1:0]    victim_tag;

    burst_cache_fsm #(
        .TAG_WIDTH  (TAG_WIDTH),
        .LINE_WIDTH (LINE_WIDTH),
        .KEY_WIDTH  (KEY_WIDTH),
        .WRITE_BACK (WRITE_BACK)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .write_en   (write_en),
        .line_hit   (line_hit),
        .line_dirty (line_dirty),
        .line_tag   (line_tag),
        .line_key   (line_key),
        .mack       (mack),
        .state      (state),
        .beat       (beat),
        .victim_key (victim_key),
        .victim_tag (victim_tag)
    );

    assign stall = en && !hit;
    assign out   = line_out;

    // LRU timestamp: advances on every requesting cycle, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset)
            set_tick <= 32'd1;
        else if (en)
            set_tick <= set_tick + 32'd1;
    end

    // Per-state set command and memory request muxing; everything idle defaults to zero.
    always_comb begin
        hit        = 1'b0;
        by_tag     = 1'b0;
        target_tag = '0;
        set_tag    = '0;
        target_key = '0;
        index      = '0;
        ctrl       = CTRL_NOP;
        write_data = '0;
        mreq       = 1'b0;
        mwrite_en  = 1'b0;
        maddr      = '0;
        mdata      = '0;
        case (state)
            ST_IDLE: begin
                by_tag     = 1'b1;
                target_tag = tag;
                index      = offset;
                if (en && line_hit) begin
                    if (!write_en) begin
                        ctrl = CTRL_READ;
                        hit  = 1'b1;
                    end else begin
                        // Write-through completes only once memory accepts the store.
                        ctrl       = CTRL_WRITE;
                        write_data = data;
                        hit        = (WRITE_BACK != 0);
                    end
                end
            end
            ST_CHECK: begin
                // Keep the lookup presented so the set reports its victim.
                by_tag     = 1'b1;
                target_tag = tag;
                index      = offset;
            end
            ST_WRITE: begin
                target_key = victim_key;
                index      = {beat, 2'b00};
                mreq       = 1'b1;
                mwrite_en  = 1'b1;
                maddr      = 32'({victim_tag, idx, beat, 2'b00});
                mdata      = line_out;
            end
            ST_FETCH: begin
                target_key = victim_key;
                index      = {beat, 2'b00};
                mreq       = 1'b1;
                maddr      = 32'({tag, idx, beat, 2'b00});
                if (mack) begin
                    ctrl       = CTRL_FILL;
                    write_data = mout;
                end
            end
            ST_ALLOC: begin
                target_key = victim_key;
                set_tag    = tag;
                ctrl       = CTRL_ALLOC;
            end
            ST_THRU: begin
                mreq      = 1'b1;
                mwrite_en = 1'b1;
                maddr     = 32'({tag, idx, offset});
                mdata     = data;
                hit       = mack;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_burst_cache_ctrl.sv
// Scoreboard bench: a write-back and a write-through controller share stimulus.
module tb_burst_cache_ctrl;
    import cache_pkg::*;

    localparam int TW = 20, SW = 6, LW = 6, KW = 2;
    localparam logic [KW-1:0] VKEY = 2'd2;
    localparam logic [TW-1:0] T0 = 20'h0ABCD, T1 = 20'h12345, T2 = 20'h00777, T3 = 20'h00042;
    localparam logic [SW-1:0] IDX = 6'h05;
    localparam logic [1:0] K_MEM = 2'd0, K_CTRL = 2'd1, K_HIT = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, preload = 1'b0;
    logic en = 1'b0, write_en = 1'b0;
    logic [TW-1:0] tag = '0;
    logic [SW-1:0] idx = '0;
    logic [LW-1:0] offset = '0;
    logic [31:0] data = '0;
    logic sel_wt = 1'b0, slow = 1'b0, wt_hit = 1'b0;
    logic en_wb, en_wt;
    assign en_wb = en & ~sel_wt;
    assign en_wt = en & sel_wt;

    // write-back DUT
    logic b_hit, b_stall, b_by_tag, b_mreq, b_mwrite_en, b_mack, b_line_hit, b_line_dirty;
    logic [31:0] b_out, b_write_data, b_set_tick, b_maddr, b_mdata, b_line_out;
    logic [TW-1:0] b_target_tag, b_set_tag, b_line_tag;
    logic [KW-1:0] b_target_key, b_line_key;
    logic [LW-1:0] b_index;
    logic [2:0] b_ctrl;
    // write-through DUT
    logic t_hit, t_stall, t_by_tag, t_mreq, t_mwrite_en, t_mack, t_line_hit, t_line_dirty;
    logic [31:0] t_out, t_write_data, t_set_tick, t_maddr, t_mdata, t_line_out;
    logic [TW-1:0] t_target_tag, t_set_tag, t_line_tag;
    logic [KW-1:0] t_target_key, t_line_key;
    logic [LW-1:0] t_index;
    logic [2:0] t_ctrl;

    logic [31:0] mout;

    burst_cache_ctrl #(.TAG_WIDTH(TW), .SET_WIDTH(SW), .LINE_WIDTH(LW), .KEY_WIDTH(KW), .WRITE_BACK(1)) dut_wb (
        .clk(clk), .reset(reset), .en(en_wb), .write_en(write_en), .tag(tag), .idx(idx), .offset(offset),
        .data(data), .hit(b_hit), .stall(b_stall), .out(b_out), .by_tag(b_by_tag), .target_tag(b_target_tag),
        .set_tag(b_set_tag), .target_key(b_target_key), .index(b_index), .ctrl(b_ctrl), .write_data(b_write_data),
        .set_tick(b_set_tick), .line_hit(b_line_hit), .line_dirty(b_line_dirty), .line_out(b_line_out),
        .line_tag(b_line_tag), .line_key(b_line_key), .mreq(b_mreq), .mwrite_en(b_mwrite_en), .maddr(b_maddr),
        .mdata(b_mdata), .mack(b_mack), .mout(mout));

    burst_cache_ctrl #(.TAG_WIDTH(TW), .SET_WIDTH(SW), .LINE_WIDTH(LW), .KEY_WIDTH(KW), .WRITE_BACK(0)) dut_wt (
        .clk(clk), .reset(reset), .en(en_wt), .write_en(write_en), .tag(tag), .idx(idx), .offset(offset),
        .data(data), .hit(t_hit), .stall(t_stall), .out(t_out), .by_tag(t_by_tag), .target_tag(t_target_tag),
        .set_tag(t_set_tag), .target_key(t_target_key), .index(t_index), .ctrl(t_ctrl), .write_data(t_write_data),
        .set_tick(t_set_tick), .line_hit(t_line_hit), .line_dirty(t_line_dirty), .line_out(t_line_out),
        .line_tag(t_line_tag), .line_key(t_line_key), .mreq(t_mreq), .mwrite_en(t_mwrite_en), .maddr(t_maddr),
        .mdata(t_mdata), .mack(t_mack), .mout(mout));

    // view of whichever DUT is active
    logic v_hit, v_stall, v_mreq, v_mwrite_en;
    logic [31:0] v_out, v_write_data, v_set_tick, v_maddr, v_mdata;
    logic [TW-1:0] v_set_tag;
    logic [KW-1:0] v_target_key;
    logic [2:0] v_ctrl;
    always_comb begin
        v_hit = sel_wt ? t_hit : b_hit;
        v_stall = sel_wt ? t_stall : b_stall;
        v_mreq = sel_wt ? t_mreq : b_mreq;
        v_mwrite_en = sel_wt ? t_mwrite_en : b_mwrite_en;
        v_out = sel_wt ? t_out : b_out;
        v_write_data = sel_wt ? t_write_data : b_write_data;
        v_set_tick = sel_wt ? t_set_tick : b_set_tick;
        v_maddr = sel_wt ? t_maddr : b_maddr;
        v_mdata = sel_wt ? t_mdata : b_mdata;
        v_set_tag = sel_wt ? t_set_tag : b_set_tag;
        v_target_key = sel_wt ? t_target_key : b_target_key;
        v_ctrl = sel_wt ? t_ctrl : b_ctrl;
    end

    // memory: acks immediately, or on the third cycle of each request when slow
    logic [1:0] wcnt;
    logic m_ack;
    assign m_ack = v_mreq && (!slow || wcnt == 2'd2);
    assign b_mack = m_ack & ~sel_wt;
    assign t_mack = m_ack & sel_wt;
    assign mout = v_maddr ^ 32'h5A5A_0000;
    always @(posedge clk) begin
        if (reset || !v_mreq || m_ack) wcnt <= 2'd0;
        else wcnt <= wcnt + 2'd1;
    end

    // one-way set model behind the write-back DUT
    logic [31:0] m_data [16];
    logic [TW-1:0] m_tag;
    logic m_valid, m_dirty;
    always_comb begin
        b_line_hit = b_by_tag && m_valid && (m_tag == b_target_tag);
        b_line_out = m_data[b_index[LW-1:2]];
        b_line_tag = m_tag;
        b_line_key = VKEY;
        b_line_dirty = m_dirty;
    end
    always @(posedge clk) begin
        if (preload) begin
            for (int b = 0; b < 16; b++) m_data[b] <= 32'h1000_0000 + 32'(b);
            m_tag <= T0; m_valid <= 1'b1; m_dirty <= 1'b0;
        end else begin
            case (b_ctrl)
                3'b101: begin m_data[b_index[LW-1:2]] <= b_write_data; m_dirty <= 1'b1; end
                3'b001: m_data[b_index[LW-1:2]] <= b_write_data;
                3'b010: begin m_tag <= b_set_tag; m_valid <= 1'b1; m_dirty <= 1'b0; end
                default: ;
            endcase
        end
    end
    assign t_line_hit = wt_hit && t_by_tag;
    assign t_line_out = 32'h7777_0000;
    assign t_line_tag = '0;
    assign t_line_key = '0;
    assign t_line_dirty = 1'b0;

    // scoreboard
    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  code;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;
    ev_t exp_q[$];
    int n_vec = 0, n_bad = 0;

    task automatic push(input logic [1:0] k, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k; e.code = c; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input ev_t got);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected got kind=%0d code=%0d addr=%h data=%h, want no event",
                     got.kind, got.code, got.addr, got.data);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_bad++;
                $display("FAIL sb_event got kind=%0d code=%0d addr=%h data=%h, want kind=%0d code=%0d addr=%h data=%h",
                         got.kind, got.code, got.addr, got.data, e.kind, e.code, e.addr, e.data);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // monitor: memory acceptance, set commands, then completions
    always @(negedge clk) begin
        ev_t g;
        if (!reset) begin
            if (v_mreq && m_ack) begin
                g.kind = K_MEM; g.code = {2'b00, v_mwrite_en}; g.addr = v_maddr;
                g.data = v_mwrite_en ? v_mdata : 32'd0;
                check_ev(g);
            end
            if (v_ctrl != 3'b000) begin
                g.kind = K_CTRL; g.code = v_ctrl; g.addr = 32'(v_target_key);
                case (v_ctrl)
                    3'b100: g.data = v_out;
                    3'b010: g.data = 32'(v_set_tag);
                    default: g.data = v_write_data;
                endcase
                check_ev(g);
            end
            if (v_hit) begin
                g = '0; g.kind = K_HIT;
                check_ev(g);
            end
        end
    end

    function automatic logic [31:0] ad(input logic [TW-1:0] t, input logic [SW-1:0] i, input logic [LW-1:0] o);
        return 32'({t, i, o});
    endfunction

    task automatic issue(input logic wr, input logic [TW-1:0] t, input logic [SW-1:0] i,
                         input logic [LW-1:0] o, input logic [31:0] d);
        @(posedge clk); #1;
        en = 1'b1; write_en = wr; tag = t; idx = i; offset = o; data = d;
    endtask

    task automatic wait_hit(input int limit, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (v_hit) break;
            cyc++;
            if (cyc >= limit) begin
                n_vec++; n_bad++;
                $display("FAIL hit_timeout got %0d cycles without hit, want fewer than %0d", cyc, limit);
                break;
            end
        end
        @(posedge clk); #1;
        en = 1'b0; write_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got no finish, want finish before 100us");
        $fatal(1);
    end

    initial begin
        int c, nf;
        reset = 1'b1; preload = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; preload = 1'b0;
        @(negedge clk);
        chk("rst_mreq", 32'(b_mreq), 32'd0);
        chk("rst_hit", 32'(b_hit), 32'd0);
        chk("rst_ctrl", 32'(b_ctrl), 32'd0);
        chk("rst_tick", b_set_tick, 32'd1);
        repeat (5) @(negedge clk);
        chk("idle_tick", b_set_tick, 32'd1);

        // read hit, word 3
        push(K_CTRL, 3'b100, 32'd0, 32'h1000_0003);
        push(K_HIT, 3'b000, 32'd0, 32'd0);
        issue(1'b0, T0, IDX, 6'd12, 32'd0);
        wait_hit(10, c);
        chk("rdhit_lat", 32'(c), 32'd0);
        chk("rdhit_tick", b_set_tick, 32'd2);

        // write-back store hit, word 2 (line becomes dirty)
        push(K_CTRL, 3'b101, 32'd0, 32'hCAFE_F00D);
        push(K_HIT, 3'b000, 32'd0, 32'd0);
        issue(1'b1, T0, IDX, 6'd8, 32'hCAFE_F00D);
        wait_hit(10, c);
        chk("wrhit_lat", 32'(c), 32'd0);

        // dirty read miss, slow memory
        slow = 1'b1;
        for (int b = 0; b < 16; b++)
            push(K_MEM, 3'b001, ad(T0, IDX, 6'(b * 4)), (b == 2) ? 32'hCAFE_F00D : 32'h1000_0000 + 32'(b));
        for (int b = 0; b < 16; b++) begin
            push(K_MEM, 3'b000, ad(T1, IDX, 6'(b * 4)), 32'd0);
            push(K_CTRL, 3'b001, 32'(VKEY), ad(T1, IDX, 6'(b * 4)) ^ 32'h5A5A_0000);
        end
        push(K_CTRL, 3'b010, 32'(VKEY), 32'(T1));
        push(K_CTRL, 3'b100, 32'd0, ad(T1, IDX, 6'd24) ^ 32'h5A5A_0000);
        push(K_HIT, 3'b000, 32'd0, 32'd0);
        issue(1'b0, T1, IDX, 6'd24, 32'd0);
        @(negedge clk);
        chk("miss_stall", 32'(b_stall), 32'd1);
        wait_hit(300, c);
        chk("dirty_miss_cycles", 32'(c + 1), 32'd99);

        // clean read miss, fast memory: no write-back
        slow = 1'b0;
        for (int b = 0; b < 16; b++) begin
            push(K_MEM, 3'b000, ad(T2, IDX, 6'(b * 4)), 32'd0);
            push(K_CTRL, 3'b001, 32'(VKEY), ad(T2, IDX, 6'(b * 4)) ^ 32'h5A5A_0000);
        end
        push(K_CTRL, 3'b010, 32'(VKEY), 32'(T2));
        push(K_CTRL, 3'b100, 32'd0, ad(T2, IDX, 6'd4) ^ 32'h5A5A_0000);
        push(K_HIT, 3'b000, 32'd0, 32'd0);
        issue(1'b0, T2, IDX, 6'd4, 32'd0);
        wait_hit(100, c);
        chk("clean_miss_cycles", 32'(c), 32'd19);

        // miss with en dropped after one cycle, reset during fetch beat 7
        slow = 1'b1;
        for (int b = 0; b < 7; b++) begin
            push(K_MEM, 3'b000, ad(T3, IDX, 6'(b * 4)), 32'd0);
            push(K_CTRL, 3'b001, 32'(VKEY), ad(T3, IDX, 6'(b * 4)) ^ 32'h5A5A_0000);
        end
        issue(1'b0, T3, IDX, 6'd0, 32'd0);
        @(posedge clk); #1 en = 1'b0;
        nf = 0;
        for (int k = 0; k < 200 && nf < 7; k++) begin
            @(negedge clk);
            if (b_ctrl == 3'b001) nf++;
        end
        chk("fills_before_reset", 32'(nf), 32'd7);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midreset_mreq", 32'(b_mreq), 32'd0);
        chk("midreset_tick", b_set_tick, 32'd1);
        chk("midreset_idle", 32'(b_by_tag), 32'd1);

        // write-through store hit to 0x1004
        sel_wt = 1'b1; slow = 1'b0; wt_hit = 1'b1;
        push(K_CTRL, 3'b101, 32'd0, 32'hDEAD_BEEF);
        push(K_MEM, 3'b001, 32'h0000_1004, 32'hDEAD_BEEF);
        push(K_HIT, 3'b000, 32'd0, 32'd0);
        issue(1'b1, 20'h1, 6'h0, 6'h04, 32'hDEAD_BEEF);
        wait_hit(10, c);
        chk("wt_hit_cycles", 32'(c), 32'd1);

        // write-through store miss: memory only
        wt_hit = 1'b0;
        push(K_MEM, 3'b001, 32'h0000_20C8, 32'h0123_4567);
        push(K_HIT, 3'b000, 32'd0, 32'd0);
        issue(1'b1, 20'h2, 6'h3, 6'h08, 32'h0123_4567);
        wait_hit(10, c);
        chk("wt_miss_cycles", 32'(c), 32'd1);

        // write-through read hit
        wt_hit = 1'b1;
        push(K_CTRL, 3'b100, 32'd0, 32'h7777_0000);
        push(K_HIT, 3'b000, 32'd0, 32'd0);
        issue(1'b0, 20'h2, 6'h3, 6'h08, 32'd0);
        wait_hit(10, c);
        chk("wt_rdhit_lat", 32'(c), 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
